tmr_time_scheduler: RTL and testbench

//  Time-redundancy scheduler for the shared pipelined modmul datapath.
//  - Accepts one operation and issues it three times on consecutive cycles to the datapath.
//  - Captures the three results and delivers their bitwise 2-of-3 vote downstream.
//  - Reports disagreement, the faulty replica and a saturating error count.

---
 rtl/tmr_time_scheduler.sv | 166 ++++++++++++++++
 tb/tb_tmr_time_scheduler.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_time_scheduler.sv
// Time-redundancy scheduler: issues one operation three times to a shared datapath and votes the results.
// Latency: first out_valid LAT+4 cycles after accept; start-to-start throughput >= LAT+4 cycles.
// Backpressure: in_ready only in IDLE; the voted result is held in DONE until out_ready completes the transfer.
module tmr_time_scheduler #(
  parameter int W     = 64,
  parameter int LAT   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             dp_valid,
  output logic [W-1:0]     dp_a,
  output logic [W-1:0]     dp_b,
  input  logic [W-1:0]     dp_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res,
  output logic             out_mismatch,
  output logic             out_fatal,
  output logic [1:0]       out_fault_id,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clear
);

  // Counter must reach LAT+2, the cycle in which the third replica result arrives.
  localparam int CW = $clog2(LAT + 3);
  localparam logic [CW-1:0] C_CAP0 = CW'(LAT);
  localparam logic [CW-1:0] C_CAP1 = CW'(LAT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(LAT + 2);
  localparam logic [CW-1:0] C_ISSUES = CW'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_dp_a;
  logic [W-1:0]   r_dp_b;
  logic [W-1:0]   r_rep0;
  logic [W-1:0]   r_rep1;
  logic [W-1:0]   r_res;
  logic           r_mismatch;
  logic           r_fatal;
  logic [1:0]     r_fault_id;
  logic [CNT_W-1:0] r_err;

  logic           w_accept;
  logic           w_xfer;
  logic           w_last;
  logic [W-1:0]   w_maj;
  logic           w_e01;
  logic           w_e02;
  logic           w_e12;
  logic           w_mismatch;
  logic           w_fatal;
  logic [1:0]     w_fault_id;

  assign w_accept = in_valid & in_ready;
  assign w_xfer   = out_valid & out_ready;
  assign w_last   = (r_state == S_RUN) && (r_cnt == C_LAST);

  // The third replica is voted straight off dp_res in its capture cycle, so it needs no holding register.
  assign w_maj      = (r_rep0 & r_rep1) | (r_rep0 & dp_res) | (r_rep1 & dp_res);
  assign w_e01      = (r_rep0 == r_rep1);
  assign w_e02      = (r_rep0 == dp_res);
  assign w_e12      = (r_rep1 == dp_res);
  assign w_mismatch = !(w_e01 && w_e02 && w_e12);
  assign w_fatal    = !w_e01 && !w_e02 && !w_e12;

  // Identify the sole dissenting replica; all-equal and all-different both report 0.
  always_comb begin
    w_fault_id = 2'd0;
    if (w_e12 && !w_e01)      w_fault_id = 2'd1;
    else if (w_e02 && !w_e01) w_fault_id = 2'd2;
    else if (w_e01 && !w_e02) w_fault_id = 2'd3;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake/issue strobes; dp_valid is decoded from state so reset drops it at once.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    dp_valid    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        dp_valid = (r_cnt < C_ISSUES);
        if (r_cnt == C_LAST) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch and RUN cycle counter; capture points depend on cnt alone so issue/capture may overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_dp_a <= '0;
      r_dp_b <= '0;
      r_rep0 <= '0;
      r_rep1 <= '0;
    end else begin
      if (w_accept) begin
        r_dp_a <= in_a;
        r_dp_b <= in_b;
        r_cnt  <= '0;
      end else if (r_state == S_RUN && !w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_RUN && r_cnt == C_CAP0) r_rep0 <= dp_res;
      if (r_state == S_RUN && r_cnt == C_CAP1) r_rep1 <= dp_res;
    end
  end

  // Voted outputs are registered on the last capture and held through DONE and beyond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res      <= '0;
      r_mismatch <= 1'b0;
      r_fatal    <= 1'b0;
      r_fault_id <= 2'd0;
    end else if (w_last) begin
      r_res      <= w_maj;
      r_mismatch <= w_mismatch;
      r_fatal    <= w_fatal;
      r_fault_id <= w_fault_id;
    end
  end

  // Saturating count of delivered mismatching results; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            r_err <= '0;
    else if (err_clear)                                 r_err <= '0;
    else if (w_xfer && r_mismatch && (r_err != '1))     r_err <= r_err + 1'b1;
  end

  assign dp_a         = r_dp_a;
  assign dp_b         = r_dp_b;
  assign out_res      = r_res;
  assign out_mismatch = r_mismatch;
  assign out_fatal    = r_fatal;
  assign out_fault_id = r_fault_id;
  assign err_count    = r_err;

endmodule

// File: tb/tb_tmr_time_scheduler.sv
// Bench for tmr_time_scheduler: two instances (LAT=4/CNT_W=2 and LAT=1/CNT_W=16).
// Each instance gets a datapath model that returns injected replica results LAT cycles after each issue.
// Directed scenarios with hand-computed expectations.
module tb_tmr_time_scheduler;
  localparam int W = 64;
  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic rst;
  logic         in_valid [2];
  logic         in_ready [2];
  logic [W-1:0] in_a [2];
  logic [W-1:0] in_b [2];
  logic         dp_valid [2];
  logic [W-1:0] dp_a [2];
  logic [W-1:0] dp_b [2];
  logic [W-1:0] dp_res [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [W-1:0] out_res [2];
  logic         out_mismatch [2];
  logic         out_fatal [2];
  logic [1:0]   out_fault_id [2];
  logic         err_clear [2];
  logic [1:0]   err_a;
  logic [15:0]  err_b;
  logic [15:0]  err_cnt [2];
  logic [15:0]  exp_err [2];

  logic [W-1:0] inj [2][4];
  logic         pv [2][4];
  logic [1:0]   pidx [2][4];
  logic [1:0]   run_len [2];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tmr_time_scheduler #(.W(W), .LAT(LAT_A), .CNT_W(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
    .dp_valid(dp_valid[0]), .dp_a(dp_a[0]), .dp_b(dp_b[0]), .dp_res(dp_res[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_res(out_res[0]),
    .out_mismatch(out_mismatch[0]), .out_fatal(out_fatal[0]), .out_fault_id(out_fault_id[0]),
    .err_count(err_a), .err_clear(err_clear[0])
  );

  tmr_time_scheduler #(.W(W), .LAT(LAT_B), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
    .dp_valid(dp_valid[1]), .dp_a(dp_a[1]), .dp_b(dp_b[1]), .dp_res(dp_res[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_res(out_res[1]),
    .out_mismatch(out_mismatch[1]), .out_fatal(out_fatal[1]), .out_fault_id(out_fault_id[1]),
    .err_count(err_b), .err_clear(err_clear[1])
  );

  assign err_cnt[0] = {14'b0, err_a};
  assign err_cnt[1] = err_b;

  // Datapath model: the n-th consecutive issue returns inj[n] after LAT cycles; idle slots return a poison value.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        run_len[d] <= 2'd0;
        for (int s = 0; s < 4; s++) begin
          pv[d][s] <= 1'b0;
          pidx[d][s] <= 2'd0;
        end
      end else begin
        run_len[d] <= dp_valid[d] ? run_len[d] + 2'd1 : 2'd0;
        pv[d][0] <= dp_valid[d];
        pidx[d][0] <= run_len[d];
        for (int s = 1; s < 4; s++) begin
          pv[d][s] <= pv[d][s-1];
          pidx[d][s] <= pidx[d][s-1];
        end
      end
    end
  end

  always_comb begin
    dp_res[0] = pv[0][LAT_A-1] ? inj[0][pidx[0][LAT_A-1]] : 64'hBAD0_BAD0_BAD0_BAD0;
    dp_res[1] = pv[1][LAT_B-1] ? inj[1][pidx[1][LAT_B-1]] : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  function automatic void bump(input int d);
    logic [15:0] mx;
    mx = (d == 0) ? 16'd3 : 16'hFFFF;
    if (exp_err[d] != mx) exp_err[d] = exp_err[d] + 16'd1;
  endfunction

  // Issue one operation and advance to the first DONE cycle (negedge); reports timing observations.
  task automatic do_op(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r0, input logic [W-1:0] r1, input logic [W-1:0] r2,
                       output int first_ov, output logic [15:0] dpv, output logic dpa_ok);
    int guard;
    inj[d][0] = r0; inj[d][1] = r1; inj[d][2] = r2; inj[d][3] = 64'hBAD1_BAD1_BAD1_BAD1;
    first_ov = -1; dpv = '0; dpa_ok = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b1; in_a[d] = a; in_b[d] = b;
    guard = 0;
    while (!in_ready[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    in_valid[d] = 1'b0; in_a[d] = '0; in_b[d] = '0;
    for (int k = 1; k <= 15; k++) begin
      if (first_ov < 0) begin
        if (dp_valid[d]) begin
          dpv[k] = 1'b1;
          if (dp_a[d] !== a || dp_b[d] !== b) dpa_ok = 1'b0;
        end
        if (out_valid[d]) first_ov = k;
        else @(negedge clk);
      end
    end
  endtask

  task automatic handshake(input int d);
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_a[d] = '0; in_b[d] = '0;
      out_ready[d] = 1'b0; err_clear[d] = 1'b0; exp_err[d] = 16'd0;
      for (int i = 0; i < 4; i++) inj[d][i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({in_ready[d], dp_valid[d], out_valid[d], out_mismatch[d], out_fatal[d], out_fault_id[d]} !== 7'b1000000) begin
        n_fail++;
        $display("FAIL reset_flags[%0d]: got %b expected 1000000", d,
                 {in_ready[d], dp_valid[d], out_valid[d], out_mismatch[d], out_fatal[d], out_fault_id[d]});
      end
      n_checks++;
      if (out_res[d] !== '0 || dp_a[d] !== '0 || dp_b[d] !== '0 || err_cnt[d] !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_data[%0d]: got res=%h dp_a=%h dp_b=%h err=%0d expected all zero",
                 d, out_res[d], dp_a[d], dp_b[d], err_cnt[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready[0] !== 1'b1 || in_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_ready: got %b%b expected 11", in_ready[0], in_ready[1]);
    end
  endtask

  task automatic test_equal_vote(input int d);
    int fo; logic [15:0] dpv; logic ok; int lat;
    lat = (d == 0) ? LAT_A : LAT_B;
    do_op(d, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h5, 64'h5, 64'h5, fo, dpv, ok);
    n_checks++;
    if (fo !== lat + 4) begin
      n_fail++; $display("FAIL equal_first_out_valid[%0d]: got %0d expected %0d", d, fo, lat + 4);
    end
    n_checks++;
    if (dpv !== 16'h000E) begin
      n_fail++; $display("FAIL equal_dp_valid_cycles[%0d]: got %h expected 000e", d, dpv);
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL equal_dp_operands[%0d]: got %b expected 1", d, ok);
    end
    n_checks++;
    if (out_res[d] !== 64'h5 || {out_mismatch[d], out_fatal[d], out_fault_id[d], in_ready[d]} !== 5'b00000) begin
      n_fail++;
      $display("FAIL equal_vote[%0d]: got res=%h flags=%b expected res=5 flags=00000", d, out_res[d],
               {out_mismatch[d], out_fatal[d], out_fault_id[d], in_ready[d]});
    end
    handshake(d);
    n_checks++;
    if ({in_ready[d], out_valid[d]} !== 2'b10 || out_res[d] !== 64'h5 || err_cnt[d] !== exp_err[d]) begin
      n_fail++;
      $display("FAIL equal_after_xfer[%0d]: got rdy/vld=%b res=%h err=%0d expected 10 5 %0d", d,
               {in_ready[d], out_valid[d]}, out_res[d], err_cnt[d], exp_err[d]);
    end
  endtask

  task automatic test_single_fault(input int d);
    logic [W-1:0] t_r0 [4] = '{64'h5, 64'h9, 64'h6, 64'hFFFF_0000_0000_0000};
    logic [W-1:0] t_r1 [4] = '{64'h4, 64'h8, 64'h6, 64'hFFFF_0000_0000_0000};
    logic [W-1:0] t_r2 [4] = '{64'h5, 64'h8, 64'h7, 64'h0};
    logic [W-1:0] t_res [4] = '{64'h5, 64'h8, 64'h6, 64'hFFFF_0000_0000_0000};
    logic [1:0]   t_fid [4] = '{2'd2, 2'd1, 2'd3, 2'd3};
    int fo; logic [15:0] dpv; logic ok;
    for (int i = 0; i < 4; i++) begin
      do_op(d, 64'hA0 + W'(i), 64'hB0, t_r0[i], t_r1[i], t_r2[i], fo, dpv, ok);
      n_checks++;
      if (out_res[d] !== t_res[i] || {out_mismatch[d], out_fatal[d], out_fault_id[d]} !== {2'b10, t_fid[i]}) begin
        n_fail++;
        $display("FAIL single_fault[%0d][%0d]: got res=%h m/f/id=%b expected res=%h m/f/id=%b", d, i,
                 out_res[d], {out_mismatch[d], out_fatal[d], out_fault_id[d]}, t_res[i], {2'b10, t_fid[i]});
      end
      handshake(d);
      bump(d);
      n_checks++;
      if (err_cnt[d] !== exp_err[d]) begin
        n_fail++; $display("FAIL single_fault_err[%0d][%0d]: got %0d expected %0d", d, i, err_cnt[d], exp_err[d]);
      end
    end
  endtask

  task automatic test_fatal(input int d);
    logic [W-1:0] t_r0 [2] = '{64'h1, 64'hF0};
    logic [W-1:0] t_r1 [2] = '{64'h2, 64'hCC};
    logic [W-1:0] t_r2 [2] = '{64'h4, 64'hAA};
    logic [W-1:0] t_res [2] = '{64'h0, 64'hE8};
    int fo; logic [15:0] dpv; logic ok;
    for (int i = 0; i < 2; i++) begin
      do_op(d, 64'hC0, 64'hD0, t_r0[i], t_r1[i], t_r2[i], fo, dpv, ok);
      n_checks++;
      if (out_res[d] !== t_res[i] || {out_mismatch[d], out_fatal[d], out_fault_id[d]} !== 4'b1100) begin
        n_fail++;
        $display("FAIL fatal[%0d][%0d]: got res=%h m/f/id=%b expected res=%h m/f/id=1100", d, i,
                 out_res[d], {out_mismatch[d], out_fatal[d], out_fault_id[d]}, t_res[i]);
      end
      handshake(d);
      bump(d);
      n_checks++;
      if (err_cnt[d] !== exp_err[d]) begin
        n_fail++; $display("FAIL fatal_err[%0d][%0d]: got %0d expected %0d", d, i, err_cnt[d], exp_err[d]);
      end
    end
  endtask

  task automatic test_backpressure;
    int fo; logic [15:0] dpv; logic ok;
    do_op(0, 64'h1, 64'h2, 64'h5, 64'h4, 64'h5, fo, dpv, ok);
    in_valid[0] = 1'b1; in_a[0] = 64'hAAAA; in_b[0] = 64'hBBBB;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid[0], in_ready[0], dp_valid[0]} !== 3'b100 || out_res[0] !== 64'h5 ||
          {out_mismatch[0], out_fault_id[0]} !== 3'b110) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got vld/rdy/dpv=%b res=%h m/id=%b expected 100 5 110", i,
                 {out_valid[0], in_ready[0], dp_valid[0]}, out_res[0], {out_mismatch[0], out_fault_id[0]});
      end
      if (i < 4) @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    bump(0);
    n_checks++;
    if ({in_ready[0], out_valid[0]} !== 2'b10 || err_cnt[0] !== exp_err[0]) begin
      n_fail++;
      $display("FAIL backpressure_xfer: got rdy/vld=%b err=%0d expected 10 %0d", {in_ready[0], out_valid[0]},
               err_cnt[0], exp_err[0]);
    end
    @(negedge clk);
    n_checks++;
    if ({in_ready[0], out_valid[0], dp_valid[0]} !== 3'b100 || err_cnt[0] !== exp_err[0] || out_res[0] !== 64'h5) begin
      n_fail++;
      $display("FAIL backpressure_single_xfer: got rdy/vld/dpv=%b err=%0d res=%h expected 100 %0d 5",
               {in_ready[0], out_valid[0], dp_valid[0]}, err_cnt[0], exp_err[0], out_res[0]);
    end
    out_ready[0] = 1'b0;
  endtask

  task automatic test_saturation;
    int fo; logic [15:0] dpv; logic ok;
    err_clear[0] = 1'b1;
    @(negedge clk);
    err_clear[0] = 1'b0;
    exp_err[0] = 16'd0;
    n_checks++;
    if (err_cnt[0] !== 16'd0) begin
      n_fail++; $display("FAIL sat_clear_idle: got %0d expected 0", err_cnt[0]);
    end
    for (int i = 1; i <= 4; i++) begin
      do_op(0, 64'h10, 64'h20, 64'h1, 64'h2, 64'h4, fo, dpv, ok);
      handshake(0);
      n_checks++;
      if (err_cnt[0] !== ((i < 3) ? 16'(i) : 16'd3)) begin
        n_fail++; $display("FAIL sat_count[%0d]: got %0d expected %0d", i, err_cnt[0], (i < 3) ? i : 3);
      end
    end
    do_op(0, 64'h10, 64'h20, 64'h1, 64'h2, 64'h4, fo, dpv, ok);
    out_ready[0] = 1'b1; err_clear[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0; err_clear[0] = 1'b0;
    exp_err[0] = 16'd0;
    n_checks++;
    if (err_cnt[0] !== 16'd0 || out_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL sat_clear_wins: got err=%0d vld=%b expected 0 0", err_cnt[0], out_valid[0]);
    end
  endtask

  task automatic test_reset_mid_run;
    int fo; logic [15:0] dpv; logic ok;
    do_op(0, 64'h1, 64'h1, 64'h3, 64'h3, 64'h2, fo, dpv, ok);
    handshake(0);
    bump(0);
    n_checks++;
    if (err_cnt[0] !== exp_err[0]) begin
      n_fail++; $display("FAIL midrst_pre_err: got %0d expected %0d", err_cnt[0], exp_err[0]);
    end
    inj[0][0] = 64'h7; inj[0][1] = 64'h7; inj[0][2] = 64'h7;
    // Reset during issue: dp_valid must fall without waiting for a clock edge.
    @(negedge clk); in_valid[0] = 1'b1; in_a[0] = 64'h77; in_b[0] = 64'h78;
    @(negedge clk); in_valid[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dp_valid[0] !== 1'b1) begin
      n_fail++; $display("FAIL midrst_issue_active: got %b expected 1", dp_valid[0]);
    end
    rst = 1'b1;
    #1;
    exp_err[0] = 16'd0; exp_err[1] = 16'd0;
    n_checks++;
    if ({dp_valid[0], in_ready[0]} !== 2'b01 || err_cnt[0] !== 16'd0) begin
      n_fail++; $display("FAIL midrst_issue: got dpv/rdy=%b err=%0d expected 01 0", {dp_valid[0], in_ready[0]}, err_cnt[0]);
    end
    @(negedge clk); rst = 1'b0;
    // Reset at cnt=LAT, the first capture cycle.
    @(negedge clk); in_valid[0] = 1'b1;
    @(negedge clk); in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({in_ready[0], out_valid[0]} !== 2'b00) begin
      n_fail++; $display("FAIL midrst_in_run: got rdy/vld=%b expected 00", {in_ready[0], out_valid[0]});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready[0], out_valid[0], dp_valid[0]} !== 3'b100 || out_res[0] !== '0 || dp_a[0] !== '0) begin
      n_fail++;
      $display("FAIL midrst_capture: got rdy/vld/dpv=%b res=%h dp_a=%h expected 100 0 0",
               {in_ready[0], out_valid[0], dp_valid[0]}, out_res[0], dp_a[0]);
    end
    @(negedge clk); rst = 1'b0;
    do_op(0, 64'h33, 64'h34, 64'h33, 64'h33, 64'h33, fo, dpv, ok);
    n_checks++;
    if (fo !== LAT_A + 4 || out_res[0] !== 64'h33 || {out_mismatch[0], out_fatal[0], out_fault_id[0]} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_next_op: got fo=%0d res=%h flags=%b expected %0d 33 0000", fo, out_res[0],
               {out_mismatch[0], out_fatal[0], out_fault_id[0]}, LAT_A + 4);
    end
    handshake(0);
  endtask

  task automatic test_back_to_back;
    int fo; logic [15:0] dpv; logic ok;
    logic [W-1:0] vals [2] = '{64'hA, 64'hB};
    out_ready[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      do_op(1, vals[i], vals[i], vals[i], vals[i], vals[i], fo, dpv, ok);
      n_checks++;
      if (fo !== LAT_B + 4 || out_res[1] !== vals[i] || dpv !== 16'h000E) begin
        n_fail++;
        $display("FAIL b2b_op[%0d]: got fo=%0d res=%h dpv=%h expected %0d %h 000e", i, fo, out_res[1], dpv,
                 LAT_B + 4, vals[i]);
      end
      @(negedge clk);
      n_checks++;
      if ({in_ready[1], out_valid[1]} !== 2'b10 || err_cnt[1] !== exp_err[1]) begin
        n_fail++;
        $display("FAIL b2b_early_ready_xfer[%0d]: got rdy/vld=%b err=%0d expected 10 %0d", i,
                 {in_ready[1], out_valid[1]}, err_cnt[1], exp_err[1]);
      end
    end
    out_ready[1] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_equal_vote(0);
    test_single_fault(0);
    test_fatal(0);
    test_backpressure();
    test_saturation();
    test_reset_mid_run();
    test_equal_vote(1);
    test_single_fault(1);
    test_fatal(1);
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
